// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, default widths and the
// master's state encoding.
package axi_lite_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_ADDR_WIDTH = 4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_WR_RESP,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_RESP
    } master_state_e;

    // SLVERR and DECERR both have bit 1 set; OKAY and EXOKAY do not.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp[1];
    endfunction

endpackage

// File: rtl/axi_lite_if.sv
// AXI4-Lite bus bundle with manager (master) and responder (slave) views.
interface axi_lite_if
    import axi_lite_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite manager: turns one request/response transaction
// into AW+W/B or AR/R bus traffic, with every output driven from a register.
module axi_lite_master
    import axi_lite_pkg::*;
#(
    parameter int AXI_DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int AXI_ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_we,
    input  logic [AXI_ADDR_WIDTH-1:0]   req_addr,
    input  logic [AXI_DATA_WIDTH-1:0]   req_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0] req_wstrb,
    output logic                        rsp_valid,
    output logic [AXI_DATA_WIDTH-1:0]   rsp_rdata,
    output logic                        rsp_err,
    axi_lite_if.master                  m_axi
);

    localparam int STRB_WIDTH = AXI_DATA_WIDTH / 8;

    master_state_e             state_q, state_d;
    logic                      req_ready_q, req_ready_d;
    logic                      awvalid_q, awvalid_d, wvalid_q, wvalid_d;
    logic                      aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic                      bready_q, bready_d, arvalid_q, arvalid_d, rready_q, rready_d;
    logic                      we_q, we_d;
    logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [AXI_DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic [STRB_WIDTH-1:0]     wstrb_q, wstrb_d;
    logic [1:0]                resp_q, resp_d;
    logic                      rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
    logic [AXI_DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                      aw_fire, w_fire;

    assign aw_fire = awvalid_q && m_axi.awready;
    assign w_fire  = wvalid_q && m_axi.wready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rdata_q     <= '0;
            resp_q      <= RESP_OKAY;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            rdata_q     <= rdata_d;
            resp_q      <= resp_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        req_ready_d = req_ready_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        rdata_d     = rdata_q;
        resp_d      = resp_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;

        case (state_q)
            ST_IDLE: begin
                req_ready_d = 1'b1;
                // Acceptance uses the registered ready, so the first IDLE cycle after reset never accepts.
                if (req_valid && req_ready_q) begin
                    req_ready_d = 1'b0;
                    we_d        = req_we;
                    addr_d      = req_addr;
                    wdata_d     = req_wdata;
                    wstrb_d     = req_wstrb;
                    if (req_we) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = ST_WR;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = ST_RD_ADDR;
                    end
                end
            end
            ST_WR: begin
                if (aw_fire) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_fire) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if ((aw_done_q || aw_fire) && (w_done_q || w_fire)) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    bready_d  = 1'b1;
                    state_d   = ST_WR_RESP;
                end
            end
            ST_WR_RESP: begin
                if (m_axi.bvalid && bready_q) begin
                    resp_d   = m_axi.bresp;
                    bready_d = 1'b0;
                    state_d  = ST_RESP;
                end
            end
            ST_RD_ADDR: begin
                if (arvalid_q && m_axi.arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                if (m_axi.rvalid && rready_q) begin
                    rdata_d  = m_axi.rdata;
                    resp_d   = m_axi.rresp;
                    rready_d = 1'b0;
                    state_d  = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid_d = 1'b1;
                rsp_err_d   = resp_is_err(resp_q);
                if (!we_q) begin
                    rsp_rdata_d = rdata_q;
                end
                req_ready_d = 1'b1;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign req_ready     = req_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_err       = rsp_err_q;
    assign m_axi.awaddr  = addr_q;
    assign m_axi.awvalid = awvalid_q;
    assign m_axi.wdata   = wdata_q;
    assign m_axi.wstrb   = wstrb_q;
    assign m_axi.wvalid  = wvalid_q;
    assign m_axi.bready  = bready_q;
    assign m_axi.araddr  = addr_q;
    assign m_axi.arvalid = arvalid_q;
    assign m_axi.rready  = rready_q;

endmodule

// File: tb/tb_axi_lite_master.sv
// Directed bench for axi_lite_master: a delay-programmable AXI-Lite responder
// plus hand-computed cycle-accurate expectations.
module tb_axi_lite_master;
    import axi_lite_pkg::*;

    localparam int DW = 32;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [DW/8-1:0] req_wstrb;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;

    int checks = 0;
    int errors = 0;

    axi_lite_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    axi_lite_master #(.AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wstrb (req_wstrb),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .m_axi     (bus)
    );

    always #5 clk = ~clk;

    // Responder: each ready rises after its programmed number of stall cycles;
    // B/R responses launch a programmed number of cycles after the address phase.
    int          aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
    logic [1:0]  b_resp_cfg = RESP_OKAY, r_resp_cfg = RESP_OKAY;
    logic [DW-1:0] r_data_cfg = '0;
    int          aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
    logic        aw_seen, w_seen, ar_seen;
    logic        aw_now, w_now, ar_now;

    assign bus.awready = bus.awvalid && (aw_cnt >= aw_delay);
    assign bus.wready  = bus.wvalid && (w_cnt >= w_delay);
    assign bus.arready = bus.arvalid && (ar_cnt >= ar_delay);
    assign aw_now = aw_seen || (bus.awvalid && bus.awready);
    assign w_now  = w_seen || (bus.wvalid && bus.wready);
    assign ar_now = ar_seen || (bus.arvalid && bus.arready);

    always @(posedge clk) begin
        if (reset) begin
            aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_cnt <= 0; r_cnt <= 0;
            aw_seen <= 1'b0; w_seen <= 1'b0; ar_seen <= 1'b0;
            bus.bvalid <= 1'b0; bus.bresp <= RESP_OKAY;
            bus.rvalid <= 1'b0; bus.rresp <= RESP_OKAY; bus.rdata <= '0;
        end else begin
            aw_cnt <= (bus.awvalid && !bus.awready) ? aw_cnt + 1 : 0;
            w_cnt  <= (bus.wvalid && !bus.wready) ? w_cnt + 1 : 0;
            ar_cnt <= (bus.arvalid && !bus.arready) ? ar_cnt + 1 : 0;
            aw_seen <= aw_now;
            w_seen  <= w_now;
            ar_seen <= ar_now;
            if (bus.bvalid && bus.bready) bus.bvalid <= 1'b0;
            if (!bus.bvalid && aw_now && w_now) begin
                if (b_cnt >= b_delay) begin
                    bus.bvalid <= 1'b1;
                    bus.bresp  <= b_resp_cfg;
                    aw_seen    <= 1'b0;
                    w_seen     <= 1'b0;
                    b_cnt      <= 0;
                end else begin
                    b_cnt <= b_cnt + 1;
                end
            end
            if (bus.rvalid && bus.rready) bus.rvalid <= 1'b0;
            if (!bus.rvalid && ar_now) begin
                if (r_cnt >= r_delay) begin
                    bus.rvalid <= 1'b1;
                    bus.rresp  <= r_resp_cfg;
                    bus.rdata  <= r_data_cfg;
                    ar_seen    <= 1'b0;
                    r_cnt      <= 0;
                end else begin
                    r_cnt <= r_cnt + 1;
                end
            end
        end
    end

    // Monitors of request acceptances and response pulses, sampled on the edge.
    int cyc = 0, acc_count = 0, rsp_count = 0, last_acc = 0, prev_acc = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!reset && req_valid && req_ready) begin
            acc_count <= acc_count + 1;
            prev_acc  <= last_acc;
            last_acc  <= cyc;
        end
        if (!reset && rsp_valid) rsp_count <= rsp_count + 1;
    end

    logic ready_seen;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic we, input logic [AW-1:0] addr,
                                  input logic [DW-1:0] wdata, input logic [DW/8-1:0] wstrb);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_wstrb = wstrb;
    endtask

    // Steps until rsp_valid (bounded) and checks how many edges that took.
    task automatic wait_rsp(input string tag, input int expected);
        int n;
        n = 0;
        ready_seen = 1'b0;
        do begin
            step();
            n++;
            if (!rsp_valid && req_ready) ready_seen = 1'b1;
        end while (!rsp_valid && n < 20);
        check_output(tag, 64'(n), 64'(expected));
    endtask

    initial begin
        int acc0, rsp0;
        reset = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
        repeat (3) step();

        $display("[TB] reset state");
        check_output("rst_req_ready", 64'(req_ready), 64'd0);
        check_output("rst_valids", 64'({bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready}), 64'd0);
        check_output("rst_addr_data", 64'({bus.awaddr, bus.wdata, bus.wstrb}), 64'd0);
        check_output("rst_rsp", 64'({rsp_valid, rsp_err, rsp_rdata}), 64'd0);
        reset = 1'b0;
        step();
        check_output("post_rst_ready", 64'(req_ready), 64'd1);

        $display("[TB] write, zero-wait responder");
        apply_stimulus(1'b1, 4'h4, 32'hDEADBEEF, 4'hF);
        step();
        req_valid = 1'b0;
        check_output("w1_aw_w_valid", 64'({bus.awvalid, bus.wvalid}), 64'b11);
        check_output("w1_awaddr", 64'(bus.awaddr), 64'h4);
        check_output("w1_wdata_wstrb", 64'({bus.wdata, bus.wstrb}), 64'hDEADBEEF_F);
        check_output("w1_req_ready_low", 64'(req_ready), 64'd0);
        step();
        check_output("w1_after_hs", 64'({bus.awvalid, bus.wvalid, bus.bready}), 64'b001);
        wait_rsp("w1_latency", 2);
        check_output("w1_rsp_err", 64'(rsp_err), 64'd0);
        check_output("w1_ready_with_rsp", 64'(req_ready), 64'd1);

        $display("[TB] write, awready delayed");
        aw_delay = 3;
        apply_stimulus(1'b1, 4'h8, 32'h0BADF00D, 4'h3);
        step();
        req_valid = 1'b0;
        rsp0 = rsp_count;
        step();
        check_output("w2_t1", 64'({bus.awvalid, bus.wvalid, bus.bready}), 64'b100);
        step();
        step();
        check_output("w2_t3", 64'({bus.awvalid, bus.bready, bus.awaddr}), 64'({2'b10, 4'h8}));
        step();
        check_output("w2_t4", 64'({bus.awvalid, bus.wvalid, bus.bready}), 64'b001);
        wait_rsp("w2_latency", 2);
        step();
        check_output("w2_one_rsp", 64'(rsp_count - rsp0), 64'd1);
        check_output("w2_rsp_single_cycle", 64'(rsp_valid), 64'd0);
        aw_delay = 0;

        $display("[TB] read, arready/rvalid delayed");
        ar_delay = 2; r_delay = 2; r_data_cfg = 32'h12345678; r_resp_cfg = RESP_OKAY;
        apply_stimulus(1'b0, 4'hC, 32'hFFFFFFFF, 4'hF);
        step();
        req_valid = 1'b0;
        check_output("r1_arvalid", 64'({bus.arvalid, bus.araddr, bus.awvalid}), 64'({1'b1, 4'hC, 1'b0}));
        wait_rsp("r1_latency", 7);
        check_output("r1_ready_low_throughout", 64'(ready_seen), 64'd0);
        check_output("r1_rdata", 64'(rsp_rdata), 64'h12345678);
        check_output("r1_rsp_err", 64'(rsp_err), 64'd0);
        ar_delay = 0; r_delay = 0;

        $display("[TB] read SLVERR then write DECERR");
        r_data_cfg = 32'hA5A50001; r_resp_cfg = RESP_SLVERR;
        apply_stimulus(1'b0, 4'h0, 32'h0, 4'h0);
        step();
        req_valid = 1'b0;
        wait_rsp("r2_latency", 3);
        check_output("r2_err_rdata", 64'({rsp_err, rsp_rdata}), 64'({1'b1, 32'hA5A50001}));
        b_resp_cfg = RESP_DECERR;
        apply_stimulus(1'b1, 4'h2, 32'hCAFE0000, 4'h0);
        step();
        req_valid = 1'b0;
        check_output("w3_zero_wstrb", 64'({bus.wvalid, bus.wstrb}), 64'({1'b1, 4'h0}));
        wait_rsp("w3_latency", 3);
        check_output("w3_err_rdata_kept", 64'({rsp_err, rsp_rdata}), 64'({1'b1, 32'hA5A50001}));
        b_resp_cfg = RESP_OKAY; r_resp_cfg = RESP_OKAY;

        $display("[TB] reset mid-write");
        aw_delay = 100; w_delay = 100;
        apply_stimulus(1'b1, 4'h6, 32'h11112222, 4'hF);
        step();
        req_valid = 1'b0;
        step();
        check_output("rstmid_stalled", 64'({bus.awvalid, bus.awready}), 64'b10);
        rsp0 = rsp_count;
        reset = 1'b1;
        aw_delay = 0; w_delay = 0;
        step();
        check_output("rstmid_outputs", 64'({bus.awvalid, bus.wvalid, req_ready, rsp_valid}), 64'd0);
        check_output("rstmid_addr_cleared", 64'({bus.awaddr, bus.wdata}), 64'd0);
        reset = 1'b0;
        step();
        check_output("rstmid_ready_back", 64'(req_ready), 64'd1);
        step();
        check_output("rstmid_no_rsp", 64'(rsp_count - rsp0), 64'd0);

        $display("[TB] continuous req_valid, alternating we");
        acc0 = acc_count; rsp0 = rsp_count; r_data_cfg = 32'h0000BEEF;
        for (int i = 0; i < 4; i++) begin
            int n;
            apply_stimulus((i % 2) == 0, 4'hA, 32'h5A5A0000 + 32'(i), 4'hF);
            check_output("cont_ready_before_accept", 64'(req_ready), 64'd1);
            step();
            if (i > 0) check_output("cont_accept_gap", 64'(last_acc - prev_acc), 64'd4);
            n = 0;
            while (!req_ready && n < 20) begin
                step();
                n++;
            end
            check_output("cont_ready_wait", 64'(n), 64'd3);
        end
        req_valid = 1'b0;
        step();
        check_output("cont_accepts", 64'(acc_count - acc0), 64'd4);
        check_output("cont_rsps", 64'(rsp_count - rsp0), 64'd4);
        step();
        check_output("cont_no_extra_accept", 64'(acc_count - acc0), 64'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] simulation did not finish");
    end

endmodule

// File: doc/axi_lite_master.md
Name: axi_lite_master

Overview:
- AXI4-Lite initiator (manager) bridging a simple single-outstanding request/response port onto an AXI-Lite bus.
- Used to drive AXI-Lite responders such as the core's memory-mapped peripherals and the UVM DUT's slave port.
- Exactly one transaction in flight. Write address and write data are issued concurrently, and each handshake is tracked independently.

Parameters:
- AXI_DATA_WIDTH, 32, data bus width in bits (multiple of 8).
- AXI_ADDR_WIDTH, 4, byte address width in bits.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  master can accept a request.
- req_we  in  1  1=write, 0=read.
- req_addr  in  AXI_ADDR_WIDTH  byte address.
- req_wdata  in  AXI_DATA_WIDTH  write data.
- req_wstrb  in  AXI_DATA_WIDTH/8  write byte strobes.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  AXI_DATA_WIDTH  read data (valid with rsp_valid on reads).
- rsp_err  out  1  response was not OKAY/EXOKAY.
- m_axi_awaddr  out  AXI_ADDR_WIDTH.
- m_axi_awvalid  out  1.
- m_axi_awready  in  1.
- m_axi_wdata  out  AXI_DATA_WIDTH.
- m_axi_wstrb  out  AXI_DATA_WIDTH/8.
- m_axi_wvalid  out  1.
- m_axi_wready  in  1.
- m_axi_bresp  in  2.
- m_axi_bvalid  in  1.
- m_axi_bready  out  1.
- m_axi_araddr  out  AXI_ADDR_WIDTH.
- m_axi_arvalid  out  1.
- m_axi_arready  in  1.
- m_axi_rdata  in  AXI_DATA_WIDTH.
- m_axi_rresp  in  2.
- m_axi_rvalid  in  1.
- m_axi_rready  out  1.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- All outputs are registered.
- Reset values:
  - req_ready=0 during reset, then 1 in IDLE.
  - All valid/ready outputs = 0.
  - All address/data/strobe outputs = 0.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - FSM = IDLE; aw_done=w_done=0.
- FSM states: IDLE, WR (AW/W issue), WR_RESP, RD_ADDR, RD_DATA, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid: latch addr/wdata/wstrb.
  - If req_we=1: next state WR, with awvalid=wvalid=1 from the next cycle.
  - If req_we=0: next state RD_ADDR, with arvalid=1.
- WR:
  - awvalid stays high until awvalid&&awready, then aw_done=1 and awvalid=0.
  - wvalid follows the same rule independently (w_done).
  - Both handshakes in the same cycle are legal.
  - When both are done (including the same cycle), go to WR_RESP with bready=1 and clear the done flags.
- WR_RESP: on bvalid (bready high), capture bresp, set bready=0, go to RESP.
- RD_ADDR: arvalid held until arready, then arvalid=0, rready=1, go to RD_DATA.
- RD_DATA: on rvalid, capture rdata/rresp, set rready=0, go to RESP.
- RESP:
  - rsp_valid=1 for exactly one cycle.
  - rsp_err = resp[1] (SLVERR/DECERR).
  - rsp_rdata = captured rdata on reads; unchanged on writes.
  - Return to IDLE; req_ready=1 in the following cycle.
- AXI rules:
  - A valid never depends on the corresponding ready.
  - Address, data and strobe are stable while their valid is high.
  - wstrb is passed through unmodified, including all-zero.
- Minimum latency, zero-wait responder: rsp_valid asserts 3 cycles after the accept edge for both writes and reads. There is no back-to-back acceptance; accept-to-accept minimum is 4 cycles.
- A stalled responder holds the FSM indefinitely (no timeout).
- req_* changes while not accepted are ignored.
- rsp_valid has no backpressure.
- Reset mid-transaction: next edge returns every output to its reset value and the FSM to IDLE. Responders share the reset.

Decomposition:
- Package axi_lite_pkg:
  - Response codes RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11.
  - Master state enum typedef.
  - Default width constants 32/4.
- No sub-module; a single FSM file.

Test Plan:
- Write, zero-wait responder: addr=0x4, wdata=0xDEADBEEF, wstrb=0xF. AW and W seen together one cycle after accept; rsp_valid 3 cycles after accept with rsp_err=0.
- Write, awready delayed 3 cycles, wready immediate: wvalid drops after its handshake; awvalid held with stable awaddr=0x8; bready only after both handshakes; one rsp_valid.
- Read, arready and rvalid each delayed 2 cycles, rdata=0x12345678, rresp=OKAY: rsp_rdata=0x12345678, rsp_err=0; req_ready=0 throughout.
- Read with rresp=SLVERR, then write with bresp=DECERR: rsp_err=1 on both; rsp_rdata keeps the read value across the write.
- Reset asserted while awvalid is high and awready=0: next edge awvalid=wvalid=0, req_ready=0; one cycle after release req_ready=1; no rsp_valid.
- req_valid held high continuously with alternating we: exactly one transaction per IDLE visit; requests accepted 4 cycles apart minimum.
